pipelined_cpu: RTL
==================

PIPELINED_CPU -- requirements
Module: pipelined_cpu

Interface
REQ-001 Parameter REGISTER_WIDTH, default 8: register, ALU and immediate width in bits.
REQ-002 Parameter NUMBER_OF_REGISTERS, default 16: register file depth, power of two; LOG_OF_REGISTERS = log2 of it.
REQ-003 Parameter PC_WIDTH, default 8: program counter width.
REQ-004 Parameter NUM_IO_CHANNELS, default 2: memory-mapped I/O channels, 1..NUMBER_OF_REGISTERS-2.
REQ-005 INSTRUCTION_WIDTH = 4 + 3*LOG_OF_REGISTERS + REGISTER_WIDTH, derived, not overridable.
REQ-006 clock  input  1  single clock; all state updates on its rising edge.
REQ-007 isReset  input  1  reset, synchronous and active-high.
REQ-008 imemAddr  output  PC_WIDTH  instruction address, combinationally equal to pc.
REQ-009 imemData  input  INSTRUCTION_WIDTH  synchronous ROM output; data for imemAddr sampled at edge N appears during cycle N+1.
REQ-010 ioIn  input  NUM_IO_CHANNELS*REGISTER_WIDTH  input channel values; channel k occupies bits [k*REGISTER_WIDTH +: REGISTER_WIDTH].
REQ-011 ioOut  output  NUM_IO_CHANNELS*REGISTER_WIDTH  registered output channel values, same packing.
REQ-012 pc  output  PC_WIDTH  current fetch address.
REQ-013 halted  output  1  high once HALT has executed.

Function
REQ-014 Instruction fields, MSB to LSB: opcode[4], rd, rs1, rs2 (LOG_OF_REGISTERS each), imm (REGISTER_WIDTH, signed).
REQ-015 Two stages: IF issues pc; EX decodes and executes imemData when the internal flag exValid is 1.
REQ-016 In EX, the register file is read combinationally and the write lands at the same clock edge; no forwarding or interlock is needed, and back-to-back dependent instructions see the updated value.
REQ-017 Register 0 reads 0 and ignores writes.
REQ-018 Channel k maps to register index IO_BASE+k, where IO_BASE = NUMBER_OF_REGISTERS-NUM_IO_CHANNELS.
REQ-019 A read of a channel index returns ioIn channel k as sampled on the current cycle.
REQ-020 A write to a channel index updates ioOut channel k at that edge; it does not update internal storage.
REQ-021 Opcodes: 0 NOP; 1 ADD rd=rs1+rs2; 2 SUB rd=rs1-rs2; 3 MUL rd=low REGISTER_WIDTH bits of signed rs1*rs2; 4 AND; 5 OR; 6 LDI rd=imm.
REQ-022 Opcodes 7 JMP pc=imm; 8 JZ pc=imm if rs1==0; 9 HALT; 10-15 behave as NOP.
REQ-023 Arithmetic is two's complement and wraps modulo 2^REGISTER_WIDTH; there is no overflow flag.
REQ-024 A jump target is the low PC_WIDTH bits of imm, zero-extended when PC_WIDTH > REGISTER_WIDTH.
REQ-025 Sequential flow: pc increments by 1 each cycle and wraps from 2^PC_WIDTH-1 to 0.
REQ-026 Taken JMP/JZ in EX: pc <= target; exValid <= 0 for the next cycle, so exactly one fetched instruction is discarded.
REQ-027 A discarded instruction performs no register, ioOut or pc side effect.
REQ-028 An untaken JZ costs no bubble.
REQ-029 HALT: halted <= 1; pc freezes; exValid <= 0 from the next cycle; no further state changes until reset.
REQ-030 Only one EX instruction is ever active, so there are no simultaneous-write conflicts.
REQ-031 A write to rd=0 by a branch or halt is ignored.

Reset
REQ-032 While isReset=1 at an edge: pc=0, exValid=0, halted=0, all registers 0, ioOut all 0.
REQ-033 The first valid EX cycle is the second cycle after reset deasserts; the instruction at address 0 executes then.
REQ-034 Reset asserted mid-program, including during a taken branch or after HALT, overrides all other updates on that edge.

Verification
REQ-035 Program LDI r1,5; LDI r2,-3; ADD r3,r1,r2 -> r3=2; then MUL r4,r1,r1 -> r4=25.
REQ-036 LDI r1,100; ADD r2,r1,r1 (width 8) -> r2=-56 (wrap); SUB r3,r0,r1 -> r3=-100.
REQ-037 JMP 5 at address 1 -> instruction at address 2 has no effect; address 5 executes two cycles after the JMP; untaken JZ runs gapless.
REQ-038 LDI r14,7 (NUM_IO_CHANNELS=2) -> ioOut ch0=7 next edge; with ioIn ch1=-4, ADD r1,r15,r0 -> r1=-4.
REQ-039 HALT at address 3 -> halted=1, pc stays 4, registers unchanged for 20 cycles; isReset pulse -> pc=0, halted=0, all registers 0, ioOut=0.
REQ-040 Run the program of REQ-035 with a sequential fetch crossing 255 (PC_WIDTH=8) -> pc wraps to 0 and the instruction at address 0 executes.

Source files
------------

// File: rtl/pipelined_cpu.sv
// pipelined_cpu: two-stage (fetch / execute) accumulator-free register CPU.
//
// Fetch stage presents pc on imemAddr; the synchronous ROM returns the word on
// imemData one cycle later, where the execute stage decodes and retires it in
// that same cycle. Register reads are combinational and the write lands at the
// closing edge, so no forwarding or interlock is needed.
//
// The top NUM_IO_CHANNELS register indices are memory-mapped I/O: reads return
// the live ioIn channel, writes update the registered ioOut channel only.
//
// Ports:
//   clock     in   single clock, rising edge
//   isReset   in   synchronous active-high reset
//   imemAddr  out  instruction address (equals pc)
//   imemData  in   instruction word from synchronous ROM
//   ioIn      in   packed input channels, channel k at [k*REGISTER_WIDTH +: REGISTER_WIDTH]
//   ioOut     out  packed registered output channels, same packing
//   pc        out  current fetch address
//   halted    out  high once HALT has executed
module pipelined_cpu #(
    parameter int REGISTER_WIDTH      = 8,
    parameter int NUMBER_OF_REGISTERS = 16,
    parameter int PC_WIDTH            = 8,
    parameter int NUM_IO_CHANNELS     = 2,
    localparam int LOG_OF_REGISTERS   = $clog2(NUMBER_OF_REGISTERS),
    localparam int INSTRUCTION_WIDTH  = 4 + 3 * LOG_OF_REGISTERS + REGISTER_WIDTH
) (
    input  logic                                      clock,
    input  logic                                      isReset,
    output logic [PC_WIDTH-1:0]                       imemAddr,
    input  logic [INSTRUCTION_WIDTH-1:0]              imemData,
    input  logic [NUM_IO_CHANNELS*REGISTER_WIDTH-1:0] ioIn,
    output logic [NUM_IO_CHANNELS*REGISTER_WIDTH-1:0] ioOut,
    output logic [PC_WIDTH-1:0]                       pc,
    output logic                                      halted
);

    localparam int W = REGISTER_WIDTH;
    localparam int L = LOG_OF_REGISTERS;
    localparam logic [L-1:0] IO_BASE_IDX = L'(NUMBER_OF_REGISTERS - NUM_IO_CHANNELS);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_LDI  = 4'd6,
        OP_JMP  = 4'd7,
        OP_JZ   = 4'd8,
        OP_HALT = 4'd9
    } opcode_e;

    // Architectural state
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                ex_valid_q, ex_valid_d;
    logic                halted_q, halted_d;
    logic [W-1:0]        regs_q [NUMBER_OF_REGISTERS];
    logic [W-1:0]        regs_d [NUMBER_OF_REGISTERS];
    logic [W-1:0]        io_out_q [NUM_IO_CHANNELS];
    logic [W-1:0]        io_out_d [NUM_IO_CHANNELS];

    // Unpacked view of the input channels
    logic [W-1:0]        io_in_ch [NUM_IO_CHANNELS];

    generate
        for (genvar gi = 0; gi < NUM_IO_CHANNELS; gi++) begin : g_io
            assign io_in_ch[gi]         = ioIn[gi*W +: W];
            assign ioOut[gi*W +: W]     = io_out_q[gi];
        end
    endgenerate

    assign imemAddr = pc_q;
    assign pc       = pc_q;
    assign halted   = halted_q;

    // Instruction decode
    opcode_e             opcode;
    logic [L-1:0]        rd, rs1, rs2;
    logic [W-1:0]        imm;
    logic [PC_WIDTH-1:0] jump_target;

    assign opcode      = opcode_e'(imemData[INSTRUCTION_WIDTH-1 -: 4]);
    assign rd          = imemData[INSTRUCTION_WIDTH-5 -: L];
    assign rs1         = imemData[INSTRUCTION_WIDTH-5-L -: L];
    assign rs2         = imemData[W +: L];
    assign imm         = imemData[W-1:0];
    // Size cast truncates or zero-extends the unsigned immediate as needed.
    assign jump_target = PC_WIDTH'(imm);

    // Operand read: r0 is hardwired zero, I/O indices see the live input pins.
    logic [W-1:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = regs_q[rs1];
        rs2_val = regs_q[rs2];
        for (int k = 0; k < NUM_IO_CHANNELS; k++) begin
            if (rs1 == IO_BASE_IDX + L'(k)) rs1_val = io_in_ch[k];
            if (rs2 == IO_BASE_IDX + L'(k)) rs2_val = io_in_ch[k];
        end
        if (rs1 == '0) rs1_val = '0;
        if (rs2 == '0) rs2_val = '0;
    end

    // Low half of a signed product equals the low half of the unsigned one, but
    // sign-extending keeps the intent explicit.
    logic signed [2*W-1:0] mul_full;
    assign mul_full = $signed({{W{rs1_val[W-1]}}, rs1_val}) * $signed({{W{rs2_val[W-1]}}, rs2_val});

    logic         wr_en;
    logic [W-1:0] wr_data;

    always_comb begin
        pc_d       = pc_q + PC_WIDTH'(1);
        ex_valid_d = 1'b1;
        halted_d   = halted_q;
        regs_d     = regs_q;
        io_out_d   = io_out_q;
        wr_en      = 1'b0;
        wr_data    = '0;

        if (halted_q) begin
            // Frozen until reset.
            pc_d       = pc_q;
            ex_valid_d = 1'b0;
        end else if (ex_valid_q) begin
            case (opcode)
                OP_ADD: begin wr_en = 1'b1; wr_data = rs1_val + rs2_val; end
                OP_SUB: begin wr_en = 1'b1; wr_data = rs1_val - rs2_val; end
                OP_MUL: begin wr_en = 1'b1; wr_data = mul_full[W-1:0]; end
                OP_AND: begin wr_en = 1'b1; wr_data = rs1_val & rs2_val; end
                OP_OR:  begin wr_en = 1'b1; wr_data = rs1_val | rs2_val; end
                OP_LDI: begin wr_en = 1'b1; wr_data = imm; end
                OP_JMP: begin
                    // The word already fetched behind the jump is squashed.
                    pc_d       = jump_target;
                    ex_valid_d = 1'b0;
                end
                OP_JZ: begin
                    if (rs1_val == '0) begin
                        pc_d       = jump_target;
                        ex_valid_d = 1'b0;
                    end
                end
                OP_HALT: begin
                    halted_d   = 1'b1;
                    pc_d       = pc_q;
                    ex_valid_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (wr_en && rd != '0) begin
            if (rd < IO_BASE_IDX) regs_d[rd] = wr_data;
            for (int k = 0; k < NUM_IO_CHANNELS; k++) begin
                if (rd == IO_BASE_IDX + L'(k)) io_out_d[k] = wr_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            pc_q       <= '0;
            ex_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) regs_q[i] <= '0;
            for (int k = 0; k < NUM_IO_CHANNELS; k++) io_out_q[k] <= '0;
        end else begin
            pc_q       <= pc_d;
            ex_valid_q <= ex_valid_d;
            halted_q   <= halted_d;
            regs_q     <= regs_d;
            io_out_q   <= io_out_d;
        end
    end

endmodule
